// File: rtl/j1_uart.sv
`timescale 1ns/1ps
// j1_uart: memory-mapped UART with a 4-entry TX FIFO and a single-byte RX holding register
module j1_uart #(
    parameter logic [15:0] BASE_ADDR = 16'hF000,
    parameter logic [15:0] DIV_RESET = 16'd434
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_dout,
    output logic [15:0] io_din,
    input  logic        uart_rxd,
    output logic        uart_txd
);
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    logic        sel;
    logic [2:0]  reg_idx;
    logic        data_wr, div_wr, data_rd, stat_rd;
    logic [15:0] div_q, eff_div;
    logic [7:0]  fifo_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  tx_cnt_q;
    logic        tx_push, tx_pop, tx_full, tx_idle;
    logic        tx_busy_q, tx_busy_d;
    logic [9:0]  tx_sh_q, tx_sh_d;
    logic [3:0]  tx_bit_q, tx_bit_d;
    logic [15:0] tx_tmr_q, tx_tmr_d;
    logic [2:0]  sync_q;
    logic        rx_line, rx_fall, rx_pop, rx_done;
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_tmr_q, rx_tmr_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, rx_ferr_q, rx_ferr_d;

    // Address decode works on halfword index so io_addr[0] drops out naturally
    assign sel     = io_addr[15:3] == BASE_ADDR[15:3];
    assign reg_idx = io_addr[2:0] >> 1;
    assign data_wr = io_wr && sel && reg_idx == 3'd0;
    assign div_wr  = io_wr && sel && reg_idx == 3'd2;
    assign data_rd = io_rd && sel && reg_idx == 3'd0;
    assign stat_rd = io_rd && sel && reg_idx == 3'd1;
    assign eff_div = div_q < 16'd2 ? 16'd2 : div_q;

    assign tx_full  = tx_cnt_q == 3'd4;
    assign tx_pop   = !tx_busy_q && tx_cnt_q != 3'd0;
    assign tx_push  = data_wr && (!tx_full || tx_pop);
    assign tx_idle  = tx_cnt_q == 3'd0 && !tx_busy_q;
    assign uart_txd = !tx_busy_q || tx_sh_q[0];

    assign rx_line = sync_q[1];
    assign rx_fall = sync_q[2] && !sync_q[1];
    assign rx_pop  = data_rd && rx_valid_q;
    assign rx_done = rx_state_q == RX_STOP && rx_tmr_q == 16'd0;

    // Zero-wait read mux, forced to zero when not addressed so responders can be OR-ed
    assign io_din = !(io_rd && sel) ? 16'h0000 :
                    reg_idx == 3'd0 ? (rx_valid_q ? {8'h80, rx_data_q} : 16'h0000) :
                    reg_idx == 3'd1 ? {11'd0, rx_ferr_q, rx_ovr_q, rx_valid_q, tx_idle, tx_full} :
                    reg_idx == 3'd2 ? div_q : 16'h0000;

    // FIFO storage needs no reset; occupancy alone defines emptiness
    always_ff @(posedge sys_clk_i)
        if (tx_push) fifo_q[wr_ptr_q] <= io_dout[7:0];

    // TX shifter: each bit timer reloads from the divisor only at a bit boundary
    always_comb begin
        tx_busy_d = tx_busy_q;
        tx_sh_d   = tx_sh_q;
        tx_bit_d  = tx_bit_q;
        tx_tmr_d  = tx_tmr_q;
        if (tx_pop) begin
            tx_busy_d = 1'b1;
            tx_sh_d   = {1'b1, fifo_q[rd_ptr_q], 1'b0};
            tx_bit_d  = 4'd0;
            tx_tmr_d  = eff_div - 16'd1;
        end else if (tx_busy_q) begin
            if (tx_tmr_q != 16'd0) tx_tmr_d = tx_tmr_q - 16'd1;
            else if (tx_bit_q == 4'd9) tx_busy_d = 1'b0;
            else begin
                tx_sh_d  = {1'b1, tx_sh_q[9:1]};
                tx_bit_d = tx_bit_q + 4'd1;
                tx_tmr_d = eff_div - 16'd1;
            end
        end
    end

    // RX FSM next state plus holding register and sticky flag updates
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tmr_d   = rx_tmr_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        case (rx_state_q)
            RX_IDLE:
                if (rx_fall) begin
                    rx_state_d = RX_START;
                    rx_tmr_d   = (eff_div >> 1) - 16'd1;
                end
            RX_START:
                if (rx_tmr_q != 16'd0) rx_tmr_d = rx_tmr_q - 16'd1;
                else if (!rx_line) begin
                    rx_state_d = RX_DATA;
                    rx_tmr_d   = eff_div - 16'd1;
                    rx_bit_d   = 3'd0;
                end else rx_state_d = RX_IDLE;
            RX_DATA:
                if (rx_tmr_q != 16'd0) rx_tmr_d = rx_tmr_q - 16'd1;
                else begin
                    rx_sh_d    = {rx_line, rx_sh_q[7:1]};
                    rx_tmr_d   = eff_div - 16'd1;
                    rx_bit_d   = rx_bit_q + 3'd1;
                    rx_state_d = rx_bit_q == 3'd7 ? RX_STOP : RX_DATA;
                end
            RX_STOP:
                if (rx_tmr_q != 16'd0) rx_tmr_d = rx_tmr_q - 16'd1;
                else rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
        rx_valid_d = rx_done || (rx_valid_q && !rx_pop);
        rx_data_d  = rx_done && (!rx_valid_q || rx_pop) ? rx_sh_q : rx_data_q;
        rx_ovr_d   = (rx_done && rx_valid_q && !rx_pop) || (rx_ovr_q && !stat_rd);
        rx_ferr_d  = (rx_done && !rx_line) || (rx_ferr_q && !stat_rd);
    end

    // State registers; reset aborts any frame in flight
    always_ff @(posedge sys_clk_i or posedge sys_rst_i)
        if (sys_rst_i) begin
            div_q      <= DIV_RESET;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            tx_cnt_q   <= 3'd0;
            tx_busy_q  <= 1'b0;
            tx_sh_q    <= 10'h3FF;
            tx_bit_q   <= 4'd0;
            tx_tmr_q   <= 16'd0;
            sync_q     <= 3'b111;
            rx_state_q <= RX_IDLE;
            rx_tmr_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            if (div_wr) div_q <= io_dout;
            if (tx_push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (tx_pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            tx_cnt_q   <= tx_cnt_q + {2'd0, tx_push} - {2'd0, tx_pop};
            tx_busy_q  <= tx_busy_d;
            tx_sh_q    <= tx_sh_d;
            tx_bit_q   <= tx_bit_d;
            tx_tmr_q   <= tx_tmr_d;
            sync_q     <= {sync_q[1:0], uart_rxd};
            rx_state_q <= rx_state_d;
            rx_tmr_q   <= rx_tmr_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
endmodule

// File: tb/tb_j1_uart.sv
`timescale 1ns/1ps
// tb_j1_uart: directed register, TX framing, RX and reset checks at DIV=4
module tb_j1_uart;
    localparam logic [15:0] A_DATA = 16'hF000, A_STAT = 16'hF002, A_DIV = 16'hF004, A_RSV = 16'hF006;

    logic        clk = 1'b0, rst = 1'b1;
    logic        io_rd = 1'b0, io_wr = 1'b0;
    logic [15:0] io_addr = 16'h0000, io_dout = 16'h0000;
    logic [15:0] io_din;
    logic        uart_rxd = 1'b1;
    logic        uart_txd;
    int          n_chk = 0, n_fail = 0;

    j1_uart dut (
        .sys_clk_i(clk), .sys_rst_i(rst), .io_rd(io_rd), .io_wr(io_wr),
        .io_addr(io_addr), .io_dout(io_dout), .io_din(io_din),
        .uart_rxd(uart_rxd), .uart_txd(uart_txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        io_wr = 1'b1; io_addr = a; io_dout = d;
        @(posedge clk);
        #1 io_wr = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        io_rd = 1'b1; io_addr = a;
        #1 d = io_din;
        @(posedge clk);
        #1 io_rd = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (4) @(negedge clk);
        end
        uart_rxd = stop;
        repeat (4) @(negedge clk);
        uart_rxd = 1'b1;
    endtask

    task automatic get_frame(output logic [7:0] b, output logic ok);
        int n;
        n = 0; ok = 1'b0; b = 8'h00;
        while (uart_txd !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (uart_txd === 1'b0) begin
            repeat (2) @(negedge clk);
            ok = uart_txd === 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (4) @(negedge clk);
                b[i] = uart_txd;
            end
            repeat (4) @(negedge clk);
            ok = ok && uart_txd === 1'b1;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic [7:0]  b;
        logic        ok;
        int          n, len, frames;

        repeat (2) @(negedge clk);
        chk("rst_txd", uart_txd, 1'b1);
        io_rd = 1'b1; io_addr = A_STAT;
        #1 chk("rst_status", io_din, 16'h0002);
        io_addr = A_DIV;
        #1 chk("rst_div", io_din, 16'd434);
        io_rd = 1'b0;
        #1 chk("din_no_rd", io_din, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        wr(A_DIV, 16'd4);
        rd(A_DIV, d);              chk("div_rw", d, 16'h0004);
        rd(16'hE004, d);           chk("unsel_rd", d, 16'h0000);
        wr(A_RSV, 16'hFFFF);
        rd(A_RSV, d);              chk("rsv_rd", d, 16'h0000);
        rd(A_DATA, d);             chk("data_empty", d, 16'h0000);
        rd(A_STAT | 16'h0001, d);  chk("addr0_ignored", d, 16'h0002);

        wr(A_DATA, 16'h00A5);
        n = 0;
        while (uart_txd !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        len = 0;
        while (uart_txd === 1'b0 && len < 20) begin
            @(negedge clk);
            len++;
        end
        chk("tx_start_len", 16'(len), 16'd4);
        @(negedge clk);
        b[0] = uart_txd;
        for (int i = 1; i < 8; i++) begin
            repeat (4) @(negedge clk);
            b[i] = uart_txd;
        end
        chk("tx_byte_a5", {8'h00, b}, 16'h00A5);
        repeat (4) @(negedge clk);
        chk("tx_stop", uart_txd, 1'b1);
        repeat (10) @(negedge clk);
        rd(A_STAT, d);             chk("tx_idle_after", d, 16'h0002);

        frames = 0;
        fork
            begin
                for (int k = 1; k <= 5; k++) wr(A_DATA, 16'(k));
                rd(A_STAT, d);     chk("tx_full", d, 16'h0001);
                wr(A_DATA, 16'h0006);
            end
            begin
                for (int k = 1; k <= 5; k++) begin
                    get_frame(b, ok);
                    if (ok) frames++;
                    chk("burst_byte", {7'd0, ok, b}, {8'h01, 8'(k)});
                end
                get_frame(b, ok);
                chk("dropped_write", {15'd0, ok}, 16'h0000);
            end
        join
        chk("frame_count", 16'(frames), 16'd5);

        send_rx(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        rd(A_STAT, d);             chk("rx_status", d, 16'h0006);
        rd(A_DATA, d);             chk("rx_data", d, 16'h803C);
        rd(A_STAT, d);             chk("rx_status_pop", d, 16'h0002);
        rd(A_DATA, d);             chk("rx_empty_rd", d, 16'h0000);

        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        rd(A_DATA, d);             chk("ovr_data", d, 16'h8011);
        rd(A_STAT, d);             chk("ovr_flag", d, 16'h000A);
        rd(A_STAT, d);             chk("ovr_clear", d, 16'h0002);

        send_rx(8'h55, 1'b0);
        repeat (4) @(negedge clk);
        rd(A_STAT, d);             chk("ferr_flag", d, 16'h0016);
        rd(A_DATA, d);             chk("ferr_data", d, 16'h8055);
        rd(A_STAT, d);             chk("ferr_clear", d, 16'h0002);

        @(negedge clk);
        uart_rxd = 1'b0;
        @(negedge clk);
        uart_rxd = 1'b1;
        repeat (20) @(negedge clk);
        rd(A_STAT, d);             chk("glitch_none", d, 16'h0002);
        send_rx(8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        rd(A_DATA, d);             chk("after_glitch", d, 16'h805A);

        wr(A_DATA, 16'h0000);
        repeat (10) @(negedge clk);
        chk("txd_mid_frame", uart_txd, 1'b0);
        rst = 1'b1;
        #1 chk("rst_txd_async", uart_txd, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd(A_STAT, d);             chk("post_rst_status", d, 16'h0002);
        rd(A_DIV, d);              chk("post_rst_div", d, 16'd434);
        repeat (20) @(negedge clk);
        chk("post_rst_txd", uart_txd, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
